ahb_sram_slave: RTL
===================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite responder: word-organised on-chip SRAM that answers transfers issued by the
//  masters through ahb_top. Sits behind the address decoder (hsel). Handles byte/half/word
//  accesses, single and burst transfers, ERROR responses and optional wait-state insertion.
// PARAMETERS
//  BASE_ADDR  32'h1000_0000  byte address of word 0
//  DEPTH      256            number of 32-bit words (power of 2)
//  WAIT_CYC   2              wait states per data phase (used only with AHB_SLV_WAIT_EN)
// PORTS
//  H_clk      in   1   bus clock, all logic on rising edge
//  H_resetn   in   1   asynchronous active-low reset
//  hsel       in   1   slave select from decoder
//  haddr      in   32  transfer byte address
//  htrans     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  hwrite     in   1   1 write, 0 read
//  hsize      in   3   000 byte, 001 half, 010 word
//  hburst     in   3   burst type, informational only (address taken from haddr every beat)
//  hwdata     in   32  write data, valid in data phase
//  hready_in  in   1   bus HREADY; address phase accepted only when high
//  hreadyout  out  1   slave ready, reset 1
//  hresp      out  1   0 OKAY, 1 ERROR, reset 0
//  hrdata     out  32  read data, reset 0
// BEHAVIOUR
//  - Accept: hsel & hready_in & htrans[1] at a rising edge; latch addr/size/write into data-phase regs.
//  - IDLE/BUSY or unselected: no access; next data phase is OKAY with zero waits.
//  - Offset = haddr - BASE_ADDR; word index = offset[log2(DEPTH)+1:2].
//  - ERROR if offset >= DEPTH*4, hsize > 3'b010, or misaligned (half with addr[0]=1, word with addr[1:0]!=0).
//  - FSM states: IDLE, ACCESS, WAIT, ERR1, ERR2.
//    IDLE --accept ok--> ACCESS (or WAIT if waits enabled); IDLE --accept bad--> ERR1.
//    WAIT: hreadyout=0, counter down from WAIT_CYC-1; at 0 -> ACCESS.
//    ACCESS: hreadyout=1, hresp=0; next state from the address phase sampled in the same cycle.
//    ERR1: hreadyout=0, hresp=1 -> ERR2: hreadyout=1, hresp=1 -> next per address phase in ERR2.
//    No memory access in ERR1/ERR2; address phase during ERR1 ignored (hready_in low).
//  - Read: hrdata valid on last cycle of data phase (zero-wait: cycle after accept); full word
//    returned, master picks lanes. hrdata holds last value otherwise; 0 after ERROR.
//  - Write: on edge ending data phase (hreadyout=1) update only lanes selected by hsize/addr[1:0],
//    little-endian (byte n -> hwdata[8n+7:8n]).
//  - Write-then-read same word on consecutive beats: read returns merged new data (bypass), no stall.
//  - Bursts: each SEQ beat is an independent transfer; SEQ after ERROR treated like NONSEQ.
//  - Reset (any time, incl. mid-WAIT/ERR): state IDLE, counter 0, pending write dropped,
//    outputs to reset values. SRAM contents not reset.
// CONFIGURATION
//  AHB_SLV_WAIT_EN defined: every accepted OK transfer gets WAIT_CYC wait cycles
//    (hreadyout=0) before ACCESS; WAIT_CYC=0 behaves zero-wait. ERROR path unaffected.
//  AHB_SLV_WAIT_EN undefined: no WAIT state/counter; all OK transfers zero-wait; WAIT_CYC ignored.
// TESTING
//  1. Write word 32'h0000_FFF1 @ 32'h1000_0000, read back -> hrdata=32'h0000_FFF1, hresp=0, zero waits.
//  2. Byte writes 8'hAA @ 32'h1000_0005, half 16'h1234 @ 32'h1000_0006 over word 0 -> read @ 32'h1000_0004
//     returns 32'h1234_AA00 lanes 1..3 updated, lane 0 unchanged.
//  3. Word write 32'hDEAD_BEEF @ 32'h1000_0010 followed next cycle by read same address -> hrdata=32'hDEAD_BEEF.
//  4. Word read @ 32'h1000_0001 and @ 32'h1000_0400 (DEPTH=256) -> two-cycle ERROR (hreadyout 0/1, hresp 1/1),
//     memory unchanged.
//  5. With AHB_SLV_WAIT_EN, WAIT_CYC=2: 4-beat INCR write 0x1..0x4 from 32'h1000_0020 -> each beat 2 cycles
//     hreadyout=0, readback 0x1..0x4.
//  6. Assert H_resetn low during WAIT of a write -> hreadyout=1, hresp=0, hrdata=0 immediately; target word
//     not written.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave_if
// Purpose : AHB-Lite signal bundle between a master (or the bus fabric) and
//           the ahb_sram_slave responder. Clock and reset are not carried here
//           and stay as plain ports on the modules.
// Signals :
//   hsel       slave select from the address decoder
//   haddr      transfer byte address
//   htrans     00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   hwrite     1 write, 0 read
//   hsize      000 byte, 001 half, 010 word
//   hburst     burst type (informational only)
//   hwdata     write data, valid in the data phase
//   hready_in  bus HREADY seen by the slave
//   hreadyout  slave ready
//   hresp      0 OKAY, 1 ERROR
//   hrdata     read data
// Modports: master (drives the request side), slave (drives the response side)
// ----------------------------------------------------------------------------
interface ahb_sram_slave_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready_in;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hwdata, hready_in,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// ----------------------------------------------------------------------------
// ahb_sram_slave
// Purpose : AHB-Lite responder backed by a word-organised on-chip SRAM.
//           Supports byte/half/word accesses, single and burst beats (each
//           beat handled as an independent transfer), two-cycle ERROR
//           responses and optional wait-state insertion.
// Parameters:
//   BASE_ADDR  byte address of word 0
//   DEPTH      number of 32-bit words (power of 2)
//   WAIT_CYC   wait states per data phase (only with AHB_SLV_WAIT_EN)
// Ports   :
//   H_clk      bus clock, rising edge
//   H_resetn   asynchronous active-low reset
//   bus        ahb_sram_slave_if.slave (request in, hreadyout/hresp/hrdata out)
// Configuration macro:
//   AHB_SLV_WAIT_EN  when defined, every accepted OK transfer is stretched by
//                    WAIT_CYC wait cycles; when undefined all OK transfers
//                    are zero-wait and there is no wait state or counter.
// ----------------------------------------------------------------------------
module ahb_sram_slave #(
  parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
  parameter int          DEPTH     = 256,
  parameter int          WAIT_CYC  = 2
) (
  input  logic             H_clk,
  input  logic             H_resetn,
  ahb_sram_slave_if.slave  bus
);

  localparam int          AW   = $clog2(DEPTH);
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
`ifdef AHB_SLV_WAIT_EN
    , ST_WAIT
`endif
  } state_t;

  state_t state, state_nx;

  logic [31:0]   mem [DEPTH];
  logic [31:0]   offset;
  logic [AW-1:0] a_idx;
  logic [3:0]    a_lanes;
  logic          accept;
  logic          addr_bad;
  logic          take;
  logic          rd_load;
  logic [AW-1:0] rd_idx;
  logic [31:0]   rd_word;
  logic [AW-1:0] dp_idx;
  logic [3:0]    dp_lanes;
  logic          dp_write;
  logic          unused_bits;

`ifdef AHB_SLV_WAIT_EN
  localparam int CW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  logic [CW-1:0] cnt, cnt_nx;
`endif

  assign unused_bits = ^{bus.hburst, bus.htrans[0]};

  assign offset = bus.haddr - BASE_ADDR;
  assign a_idx  = offset[AW+1:2];
  assign accept = bus.hsel & bus.hready_in & bus.htrans[1];

  // Decode the address phase: byte lanes touched and whether the transfer
  // must be refused. Addresses below BASE_ADDR wrap to a huge offset and so
  // fall out of range naturally.
  always_comb begin
    a_lanes  = 4'b0000;
    addr_bad = (offset >= SPAN);
    case (bus.hsize)
      3'b000: a_lanes = 4'b0001 << bus.haddr[1:0];
      3'b001: begin
        a_lanes = bus.haddr[1] ? 4'b1100 : 4'b0011;
        if (bus.haddr[0]) addr_bad = 1'b1;
      end
      3'b010: begin
        a_lanes = 4'b1111;
        if (bus.haddr[1:0] != 2'b00) addr_bad = 1'b1;
      end
      default: addr_bad = 1'b1;
    endcase
  end

  // State register (and wait counter when waits are compiled in).
  always_ff @(posedge H_clk or negedge H_resetn) begin
    if (!H_resetn) begin
      state <= ST_IDLE;
`ifdef AHB_SLV_WAIT_EN
      cnt   <= '0;
`endif
    end else begin
      state <= state_nx;
`ifdef AHB_SLV_WAIT_EN
      cnt   <= cnt_nx;
`endif
    end
  end

  // Next state and response outputs. IDLE, ACCESS and ERR2 all end their
  // cycle with hreadyout high, so they share the address-phase decision.
  // rd_load marks the edge at which hrdata must capture the read word.
  always_comb begin
    state_nx      = state;
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    take          = 1'b0;
    rd_load       = 1'b0;
    rd_idx        = a_idx;
`ifdef AHB_SLV_WAIT_EN
    cnt_nx        = cnt;
`endif
    case (state)
      ST_ERR1: begin
        bus.hreadyout = 1'b0;
        bus.hresp     = 1'b1;
        state_nx      = ST_ERR2;
      end
`ifdef AHB_SLV_WAIT_EN
      ST_WAIT: begin
        bus.hreadyout = 1'b0;
        if (cnt == '0) begin
          state_nx = ST_ACCESS;
          rd_load  = ~dp_write;
          rd_idx   = dp_idx;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
`endif
      default: begin
        if (state == ST_ERR2) bus.hresp = 1'b1;
        if (!accept) begin
          state_nx = ST_IDLE;
        end else if (addr_bad) begin
          state_nx = ST_ERR1;
        end else begin
          take = 1'b1;
`ifdef AHB_SLV_WAIT_EN
          if (WAIT_CYC > 0) begin
            state_nx = ST_WAIT;
            cnt_nx   = CW'(WAIT_CYC - 1);
          end else begin
            state_nx = ST_ACCESS;
            rd_load  = ~bus.hwrite;
          end
`else
          state_nx = ST_ACCESS;
          rd_load  = ~bus.hwrite;
`endif
        end
      end
    endcase
  end

  // Data-phase registers, captured when an OK transfer is accepted.
  always_ff @(posedge H_clk or negedge H_resetn) begin
    if (!H_resetn) begin
      dp_idx   <= '0;
      dp_lanes <= 4'b0000;
      dp_write <= 1'b0;
    end else if (take) begin
      dp_idx   <= a_idx;
      dp_lanes <= a_lanes;
      dp_write <= bus.hwrite;
    end
  end

  // Read word with write bypass: a write finishing in this ACCESS cycle
  // lands in the array at the same edge the next read samples it, so merge
  // its lanes in here to avoid a stall.
  always_comb begin
    rd_word = mem[rd_idx];
    if (state == ST_ACCESS && dp_write && dp_idx == rd_idx) begin
      for (int n = 0; n < 4; n++) begin
        if (dp_lanes[n]) rd_word[8*n +: 8] = bus.hwdata[8*n +: 8];
      end
    end
  end

  // hrdata holds its value between reads and is cleared by an ERROR.
  always_ff @(posedge H_clk or negedge H_resetn) begin
    if (!H_resetn) begin
      bus.hrdata <= '0;
    end else if (state_nx == ST_ERR1) begin
      bus.hrdata <= '0;
    end else if (rd_load) begin
      bus.hrdata <= rd_word;
    end
  end

  // SRAM array: contents survive reset; lane-masked write at the end of an
  // ACCESS cycle. Reset forces IDLE, which drops any pending write.
  always_ff @(posedge H_clk) begin
    if (state == ST_ACCESS && dp_write) begin
      for (int n = 0; n < 4; n++) begin
        if (dp_lanes[n]) mem[dp_idx][8*n +: 8] <= bus.hwdata[8*n +: 8];
      end
    end
  end

endmodule
